// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path types: PID encodings, PID classes, length limits
// and the PID extractor state encoding.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_NYET  = 4'b0110,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_DATA2 = 4'b0111,
    PID_MDATA = 4'b1111,
    PID_PING  = 4'b0100
  } pid_t;

  localparam logic [1:0] PID_CLASS_SPECIAL   = 2'b00;
  localparam logic [1:0] PID_CLASS_TOKEN     = 2'b01;
  localparam logic [1:0] PID_CLASS_HANDSHAKE = 2'b10;
  localparam logic [1:0] PID_CLASS_DATA      = 2'b11;

  // Body lengths in bytes, counted after the PID byte.
  localparam int TOKEN_LEN     = 2;
  localparam int HANDSHAKE_LEN = 0;
  localparam int DATA_MIN_LEN  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_BODY,
    ST_DROP,
    ST_COMMIT
  } ext_state_t;

endpackage

// File: rtl/rx_pid_extractor_if.sv
// Decoded receive byte stream plus PID FIFO write port around the extractor.
interface rx_pid_extractor_if;
  logic       pkt_start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       pkt_end;
  logic       rx_error;
  logic       fifo_full;
  logic       w_enable;
  logic [7:0] w_data;
  logic       pid_err;
  logic       len_err;
  logic       overflow;
  logic       busy;

  modport master (
    output pkt_start, byte_valid, byte_data, pkt_end, rx_error, fifo_full,
    input  w_enable, w_data, pid_err, len_err, overflow, busy
  );

  modport slave (
    input  pkt_start, byte_valid, byte_data, pkt_end, rx_error, fifo_full,
    output w_enable, w_data, pid_err, len_err, overflow, busy
  );
endinterface

// File: rtl/pid_classify.sv
// Combinational PID byte check. pid_class is the raw type field; PING reports
// class 00 with is_ping set, other class-00 PIDs are reserved and not valid.
module pid_classify
  import usb_rx_pkg::*;
(
  input  logic [7:0] pid_byte,
  output logic       valid,
  output logic [1:0] pid_class,
  output logic       is_ping
);

  logic check_ok;

  always_comb begin
    check_ok  = (pid_byte[7:4] == ~pid_byte[3:0]);
    is_ping   = check_ok && (pid_byte[3:0] == PID_PING);
    pid_class = pid_byte[1:0];
    valid     = check_ok && ((pid_byte[1:0] != PID_CLASS_SPECIAL) || is_ping);
  end

endmodule

// File: rtl/rx_pid_extractor.sv
// Captures and validates each packet's PID, checks body length against the
// PID class, and writes the PID to the FIFO only for cleanly ended packets.
//
// state     | meaning
// ST_IDLE   | no packet in progress
// ST_PID    | SYNC seen, waiting for the PID byte
// ST_BODY   | counting body bytes, collecting rx_error
// ST_DROP   | bad PID, discarding until EOP
// ST_COMMIT | one cycle: write PID or flag overflow
module rx_pid_extractor
  import usb_rx_pkg::*;
#(
  parameter int MAX_DATA = 64,
  parameter int CNT_W    = 7
) (
  input logic             clk,
  input logic             n_rst,
  rx_pid_extractor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ext_state_t       state, state_d;
  logic [7:0]       pid_reg, pid_reg_d;
  logic [1:0]       cls_reg, cls_reg_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d, cnt_inc;
  logic             err_seen, err_seen_d;
  logic             pid_err_q, pid_err_d;
  logic             len_err_q, len_err_d;
  logic [7:0]       w_data_q;
  logic             pid_valid, pid_is_ping;
  logic [1:0]       pid_raw_cls, pid_cls;

  pid_classify u_classify (
    .pid_byte  (bus.byte_data),
    .valid     (pid_valid),
    .pid_class (pid_raw_cls),
    .is_ping   (pid_is_ping)
  );

  function automatic logic len_ok(input logic [1:0] cls, input logic [CNT_W-1:0] n);
    case (cls)
      PID_CLASS_TOKEN:     len_ok = (n == CNT_W'(TOKEN_LEN));
      PID_CLASS_HANDSHAKE: len_ok = (n == CNT_W'(HANDSHAKE_LEN));
      PID_CLASS_DATA:      len_ok = (n >= CNT_W'(DATA_MIN_LEN)) && (n <= CNT_W'(MAX_DATA + 2));
      default:             len_ok = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      pid_reg   <= '0;
      cls_reg   <= '0;
      byte_cnt  <= '0;
      err_seen  <= 1'b0;
      pid_err_q <= 1'b0;
      len_err_q <= 1'b0;
      w_data_q  <= '0;
    end else begin
      state     <= state_d;
      pid_reg   <= pid_reg_d;
      cls_reg   <= cls_reg_d;
      byte_cnt  <= byte_cnt_d;
      err_seen  <= err_seen_d;
      pid_err_q <= pid_err_d;
      len_err_q <= len_err_d;
      if (bus.w_enable) w_data_q <= pid_reg;
    end
  end

  always_comb begin
    state_d    = state;
    pid_reg_d  = pid_reg;
    cls_reg_d  = cls_reg;
    byte_cnt_d = byte_cnt;
    err_seen_d = err_seen;
    pid_err_d  = 1'b0;
    len_err_d  = 1'b0;
    pid_cls    = pid_is_ping ? PID_CLASS_TOKEN : pid_raw_cls;
    cnt_inc    = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + CNT_W'(1);

    if (bus.pkt_start) begin
      state_d    = ST_PID;
      byte_cnt_d = '0;
      err_seen_d = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_PID: begin
          if (bus.rx_error) err_seen_d = 1'b1;
          if (bus.byte_valid) begin
            if (!pid_valid) begin
              pid_err_d = 1'b1;
              state_d   = bus.pkt_end ? ST_IDLE : ST_DROP;
            end else begin
              pid_reg_d = bus.byte_data;
              cls_reg_d = pid_cls;
              // PID and EOP together means an empty body; judge it right away.
              if (!bus.pkt_end) begin
                state_d = ST_BODY;
              end else if (len_ok(pid_cls, '0) && !err_seen_d) begin
                state_d = ST_COMMIT;
              end else begin
                len_err_d = 1'b1;
                state_d   = ST_IDLE;
              end
            end
          end else if (bus.pkt_end) begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_BODY: begin
          if (bus.byte_valid) byte_cnt_d = cnt_inc;
          if (bus.rx_error)   err_seen_d = 1'b1;
          if (bus.pkt_end) begin
            if (len_ok(cls_reg, byte_cnt_d) && !err_seen_d) begin
              state_d = ST_COMMIT;
            end else begin
              len_err_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
        ST_DROP:   if (bus.pkt_end) state_d = ST_IDLE;
        ST_COMMIT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.w_enable = (state == ST_COMMIT) && !bus.fifo_full;
    bus.overflow = (state == ST_COMMIT) && bus.fifo_full;
    bus.w_data   = bus.w_enable ? pid_reg : w_data_q;
    bus.pid_err  = pid_err_q;
    bus.len_err  = len_err_q;
    bus.busy     = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_rx_pid_extractor.sv
// Directed bench for rx_pid_extractor with hand-computed expected outputs.
module tb_rx_pid_extractor;

  logic clk;
  logic n_rst;
  int   checks   = 0;
  int   failures = 0;

  int n_we = 0, n_pe = 0, n_le = 0, n_ov = 0, n_multi = 0;
  int s_we = 0, s_pe = 0, s_le = 0, s_ov = 0;

  rx_pid_extractor_if bus ();

  rx_pid_extractor #(.MAX_DATA(64), .CNT_W(7)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (n_rst) begin
      n_we <= n_we + int'(bus.w_enable);
      n_pe <= n_pe + int'(bus.pid_err);
      n_le <= n_le + int'(bus.len_err);
      n_ov <= n_ov + int'(bus.overflow);
      if ((int'(bus.w_enable) + int'(bus.pid_err) + int'(bus.len_err) + int'(bus.overflow)) > 1)
        n_multi <= n_multi + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [7:0] wd,
                         input logic pe, input logic le, input logic ov);
    chk({tag, ".w_enable"}, 32'(bus.w_enable), 32'(we));
    chk({tag, ".w_data"},   32'(bus.w_data),   32'(wd));
    chk({tag, ".pid_err"},  32'(bus.pid_err),  32'(pe));
    chk({tag, ".len_err"},  32'(bus.len_err),  32'(le));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] d,
                     input logic e, input logic err);
    bus.pkt_start  = s;
    bus.byte_valid = v;
    bus.byte_data  = d;
    bus.pkt_end    = e;
    bus.rx_error   = err;
    tick();
    bus.pkt_start  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.pkt_end    = 1'b0;
    bus.rx_error   = 1'b0;
  endtask

  // SYNC, PID byte, nbody body bytes (rx_error on byte err_at), then EOP.
  task automatic send(input logic [7:0] pid, input int nbody, input int err_at);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, pid, 1'b0, 1'b0);
    for (int i = 0; i < nbody; i++)
      cyc(1'b0, 1'b1, 8'(i + 16), 1'b0, (i == err_at));
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Pulse totals since the previous call; ticks once so the result cycle is counted.
  task automatic chk_counts(input string tag, input int we, input int pe, input int le, input int ov);
    tick();
    chk({tag, ".n_we"}, 32'(n_we - s_we), 32'(we));
    chk({tag, ".n_pe"}, 32'(n_pe - s_pe), 32'(pe));
    chk({tag, ".n_le"}, 32'(n_le - s_le), 32'(le));
    chk({tag, ".n_ov"}, 32'(n_ov - s_ov), 32'(ov));
    s_we = n_we; s_pe = n_pe; s_le = n_le; s_ov = n_ov;
  endtask

  initial begin
    n_rst          = 1'b0;
    bus.pkt_start  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.pkt_end    = 1'b0;
    bus.rx_error   = 1'b0;
    bus.fifo_full  = 1'b0;
    tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    n_rst = 1'b1;
    tick();

    // IDLE ignores stray bytes and EOP
    cyc(1'b0, 1'b1, 8'hE1, 1'b1, 1'b0);
    chk("idle_ignore.busy", 32'(bus.busy), 32'd0);
    chk_counts("idle_ignore", 0, 0, 0, 0);

    // OUT token with two body bytes
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("out.busy", 32'(bus.busy), 32'd1);
    cyc(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("out", 1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    chk_counts("out", 1, 0, 0, 0);
    chk("out.hold_w_data", 32'(bus.w_data), 32'hE1);
    chk("out.idle_busy", 32'(bus.busy), 32'd0);

    // ACK with EOP on the PID byte itself
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hD2, 1'b1, 1'b0);
    chk_out("ack", 1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
    chk_counts("ack", 1, 0, 0, 0);

    // ACK with one body byte is too long
    send(8'hD2, 1, -1);
    chk_out("ack_long", 1'b0, 8'hD2, 1'b0, 1'b1, 1'b0);
    chk_counts("ack_long", 0, 0, 1, 0);

    // bad check field: pid_err right after the byte, then silence until EOP
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hE2, 1'b0, 1'b0);
    chk_out("bad_chk", 1'b0, 8'hD2, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("bad_chk_eop", 1'b0, 8'hD2, 1'b0, 1'b0, 1'b0);
    chk_counts("bad_chk", 0, 1, 0, 0);

    // reserved PID 0000
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    chk("reserved.pid_err", 32'(bus.pid_err), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_counts("reserved", 0, 1, 0, 0);

    // EOP before any PID byte
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("empty", 1'b0, 8'hD2, 1'b0, 1'b1, 1'b0);
    chk_counts("empty", 0, 0, 1, 0);

    // DATA0 at maximum length, one over, and with rx_error
    send(8'hC3, 66, -1);
    chk_out("data_max", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    chk_counts("data_max", 1, 0, 0, 0);
    send(8'hC3, 67, -1);
    chk_out("data_over", 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);
    chk_counts("data_over", 0, 0, 1, 0);
    send(8'hC3, 10, 5);
    chk_out("data_rxerr", 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);
    chk_counts("data_rxerr", 0, 0, 1, 0);

    // DATA1 length boundaries: 1 byte is short, 2 bytes (empty payload) is fine
    send(8'h4B, 1, -1);
    chk_counts("data_short", 0, 0, 1, 0);
    send(8'h4B, 2, -1);
    chk_out("data_min", 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0);
    chk_counts("data_min", 1, 0, 0, 0);

    // PING is a token
    send(8'hB4, 2, -1);
    chk_out("ping", 1'b1, 8'hB4, 1'b0, 1'b0, 1'b0);
    chk_counts("ping", 1, 0, 0, 0);

    // IN completes while FIFO is full
    bus.fifo_full = 1'b1;
    send(8'h69, 2, -1);
    chk_out("in_full", 1'b0, 8'hB4, 1'b0, 1'b0, 1'b1);
    chk_counts("in_full", 0, 0, 0, 1);
    bus.fifo_full = 1'b0;

    // DATA1 abandoned by a new SYNC; the SETUP that follows is written
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h4B, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    send(8'h2D, 2, -1);
    chk_out("abandon", 1'b1, 8'h2D, 1'b0, 1'b0, 1'b0);
    chk_counts("abandon", 1, 0, 0, 0);

    // async reset in the middle of a body
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    chk("mid_body.busy", 32'(bus.busy), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("async_rst.busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    send(8'hA5, 2, -1);
    chk_out("sof", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk_counts("sof", 1, 0, 0, 0);

    chk("exclusive_pulses", 32'(n_multi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_pid_extractor.md
Name: rx_pid_extractor

Overview:
Sits directly upstream of the receiver's PID FIFO. It watches the decoded USB receive byte stream, captures and validates the PID byte of each packet, and checks body length against the PID class. It writes the PID into the FIFO only when the packet terminates cleanly, so the FIFO holds the exact order of good packets received.

Parameters:
MAX_DATA, 64, maximum data-packet payload in bytes, excluding the 2 CRC16 bytes.
CNT_W, 7, byte-counter width; must satisfy 2^CNT_W > MAX_DATA+2.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
pkt_start  in  1  1-cycle pulse: SYNC detected, new packet begins
byte_valid  in  1  byte_data holds a received byte this cycle
byte_data  in  8  received byte; bits[3:0]=PID, bits[7:4]=check field
pkt_end  in  1  1-cycle pulse: EOP detected
rx_error  in  1  level: bit-stuff or decode error in the current packet
fifo_full  in  1  full flag from the PID FIFO
w_enable  out  1  write strobe to the PID FIFO
w_data  out  8  PID byte to the FIFO
pid_err  out  1  1-cycle pulse: PID check failed or reserved PID
len_err  out  1  1-cycle pulse: body length illegal for the PID class, or rx_error during the packet
overflow  out  1  1-cycle pulse: good PID lost because fifo_full was high
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, n_rst=0): state=IDLE; all outputs 0; pid_reg=0; byte_cnt=0; err_seen=0.
- States: IDLE, PID, BODY, DROP, COMMIT.
- pkt_start has top priority in every state: go to PID; clear byte_cnt and err_seen. Any packet in progress is silently abandoned, with no error pulse.
- IDLE: byte_valid and pkt_end are ignored.
- PID, on byte_valid:
  - Legality check: byte_data[7:4] must equal ~byte_data[3:0].
  - Type from bits[1:0]: 01 token, 10 handshake, 11 data.
  - Type 00: only PING (4'b0100) is legal, treated as a token. 0000, 1000 and 1100 are reserved.
  - Check fails or PID reserved: pid_err pulses in the next cycle, then go to DROP.
  - Otherwise latch pid_reg and go to BODY.
- PID, on pkt_end with no byte received: len_err pulse, then go to IDLE.
- BODY:
  - Each byte_valid increments byte_cnt, saturating at 2^CNT_W-1.
  - rx_error high in any cycle sets err_seen.
  - If byte_valid and pkt_end arrive in the same cycle, count the byte first, then evaluate.
- On pkt_end in BODY, the required byte_cnt is:
  - token: 2
  - handshake: 0
  - data: 2 to MAX_DATA+2 inclusive
- On pkt_end in BODY, the result is:
  - Length wrong or err_seen set: len_err pulse, go to IDLE.
  - Otherwise: go to COMMIT.
- DROP: wait for pkt_end, then go to IDLE. No further pulses are issued.
- COMMIT lasts exactly one cycle, then go to IDLE.
  - fifo_full=0: w_enable=1 and w_data=pid_reg.
  - fifo_full=1: overflow=1 and no write.
  - The extractor never stalls; the bus cannot be back-pressured.
- Latency: pkt_end sampled at edge k puts COMMIT in cycle k+1, so w_enable is high during cycle k+1. Error pulses also appear in cycle k+1.
- w_data holds its last written value between writes.
- At most one of pid_err, len_err, overflow, w_enable is high in any cycle.

Decomposition:
- Shared package usb_rx_pkg holds:
  - pid_t enum of the 4-bit PIDs (OUT, IN, SOF, SETUP, ACK, NAK, STALL, NYET, DATA0/1/2, MDATA, PING).
  - PID class constants (TOKEN=2'b01, HANDSHAKE=2'b10, DATA=2'b11).
  - Expected-length constants.
  - The extractor state enum.
- One combinational sub-module, pid_classify: takes the byte and outputs valid, class and is_ping. It is reused by the downstream packet decoder.

Test Plan:
1. pkt_start; byte 0xE1 (OUT); bytes 0x12, 0x34; pkt_end with fifo_full=0 -> one cycle later w_enable=1 and w_data=0xE1; no error pulses.
2. pkt_start; byte 0xD2 (ACK); pkt_end in the same cycle as that byte -> w_enable with w_data=0xD2. Same sequence with one extra body byte -> len_err, no write.
3. pkt_start; byte 0xE2 (bad check field) -> pid_err in the next cycle; following bytes and pkt_end produce nothing. Byte 0xF0 (reserved 0000) -> pid_err.
4. DATA0 (0xC3) with 66 body bytes -> write 0xC3. With 67 bytes (MAX_DATA=64) -> len_err. With rx_error pulsed mid-body -> len_err.
5. Valid IN (0x69) completes while fifo_full=1 -> overflow pulse, w_enable stays 0. A second pkt_start mid-body of a DATA1 -> abandoned silently; the new packet is processed normally.
6. Assert n_rst mid-BODY -> all outputs 0 immediately. After release, the next complete SOF (0xA5, 2 bytes) is written normally.
